rmii_rx_deframer: RTL

Receive-side RMII front end for the engineer-station network path. Samples the 2-bit RMII receive bus at 50 MHz, detects preamble and SFD, and assembles LSB-first dibits into bytes. Delivers a frame-start pulse, a frame-active level and a per-byte strobe to the downstream MAC receive parser, which counts DMAC/SMAC/TYPE/application-data bytes on those strobes.

---
 rtl/rmii_rx_deframer_if.sv | 22 ++
 rtl/rmii_rx_deframer.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/rmii_rx_deframer_if.sv
// RMII receive dibit bus plus the deframer outputs consumed by the MAC receive parser.
`timescale 1ns/1ps
interface rmii_rx_deframer_if;
    logic       i_rxdv;
    logic [1:0] im_rxdata;
    logic       o_mac_start;
    logic       o_d_flag;
    logic       o_d_sync;
    logic [7:0] om_data;
    logic       o_frame_end;
    logic       o_crc_err;

    modport master (
        input  i_rxdv, im_rxdata,
        output o_mac_start, o_d_flag, o_d_sync, om_data, o_frame_end, o_crc_err
    );

    modport slave (
        output i_rxdv, im_rxdata,
        input  o_mac_start, o_d_flag, o_d_sync, om_data, o_frame_end, o_crc_err
    );
endinterface

// File: rtl/rmii_rx_deframer.sv
// RMII receive deframer: preamble/SFD detection and LSB-first dibit-to-byte assembly.
// Optional FCS check enabled by defining RMII_RX_CRC_CHK_EN.
`timescale 1ns/1ps
module rmii_rx_deframer #(
    parameter int PREAMBLE_MIN = 8,
    parameter int MAX_BYTES    = 1522
) (
    input logic                i_clk_50m,
    input logic                i_rstn,
    rmii_rx_deframer_if.master bus
);
    localparam logic [4:0]  PRE_MIN = 5'(PREAMBLE_MIN);
    localparam logic [4:0]  RUN_SAT = 5'd31;
    localparam logic [10:0] MAX_B   = 11'(MAX_BYTES);

    typedef enum logic [1:0] {IDLE, PREAMBLE, DATA, DROP} state_t;

    state_t      state, state_nxt;
    logic [4:0]  run, run_nxt;
    logic        mac_start_nxt, d_flag_nxt, frame_end_nxt, sfd_hit, shift_en;
    logic        mac_start, d_flag, d_sync, frame_end;
    logic [1:0]  dcnt;
    logic [10:0] bcnt;
    logic [7:0]  shreg, data;
    logic [7:0]  byte_nxt;
    logic        byte_done, deliver;

    assign byte_nxt  = {bus.im_rxdata, shreg[7:2]};
    assign byte_done = shift_en && (dcnt == 2'd3);
    assign deliver   = byte_done && (bcnt < MAX_B);

    always_ff @(posedge i_clk_50m or negedge i_rstn) begin
        if (!i_rstn) begin
            state <= IDLE;
            run   <= 5'd0;
        end else begin
            state <= state_nxt;
            run   <= run_nxt;
        end
    end

    always_comb begin
        state_nxt     = state;
        run_nxt       = run;
        mac_start_nxt = 1'b0;
        d_flag_nxt    = 1'b0;
        frame_end_nxt = 1'b0;
        sfd_hit       = 1'b0;
        shift_en      = 1'b0;
        case (state)
            IDLE: begin
                if (bus.i_rxdv) begin
                    if (bus.im_rxdata == 2'b01) begin
                        state_nxt = PREAMBLE;
                        run_nxt   = 5'd1;
                    end else begin
                        state_nxt = DROP;
                    end
                end
            end
            PREAMBLE: begin
                if (!bus.i_rxdv) begin
                    state_nxt = IDLE;
                end else if (bus.im_rxdata == 2'b01) begin
                    if (run != RUN_SAT) run_nxt = run + 5'd1;
                end else if (bus.im_rxdata == 2'b11 && run >= PRE_MIN) begin
                    state_nxt     = DATA;
                    mac_start_nxt = 1'b1;
                    sfd_hit       = 1'b1;
                end else begin
                    state_nxt = DROP;
                end
            end
            DATA: begin
                // Past MAX_BYTES the frame stays open (flag high) but strobes are gated off.
                if (bus.i_rxdv) begin
                    shift_en   = 1'b1;
                    d_flag_nxt = 1'b1;
                end else begin
                    state_nxt     = IDLE;
                    frame_end_nxt = 1'b1;
                end
            end
            DROP: begin
                if (!bus.i_rxdv) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge i_clk_50m or negedge i_rstn) begin
        if (!i_rstn) begin
            mac_start <= 1'b0;
            d_flag    <= 1'b0;
            d_sync    <= 1'b0;
            frame_end <= 1'b0;
        end else begin
            mac_start <= mac_start_nxt;
            d_flag    <= d_flag_nxt;
            d_sync    <= deliver;
            frame_end <= frame_end_nxt;
        end
    end

    always_ff @(posedge i_clk_50m or negedge i_rstn) begin
        if (!i_rstn) begin
            dcnt  <= 2'd0;
            bcnt  <= 11'd0;
            shreg <= 8'd0;
            data  <= 8'd0;
        end else if (sfd_hit) begin
            dcnt  <= 2'd0;
            bcnt  <= 11'd0;
            shreg <= 8'd0;
        end else if (shift_en) begin
            shreg <= byte_nxt;
            dcnt  <= dcnt + 2'd1;
            if (deliver) begin
                data <= byte_nxt;
                bcnt <= bcnt + 11'd1;
            end
        end
    end

    assign bus.o_mac_start = mac_start;
    assign bus.o_d_flag    = d_flag;
    assign bus.o_d_sync    = d_sync;
    assign bus.om_data     = data;
    assign bus.o_frame_end = frame_end;

`ifdef RMII_RX_CRC_CHK_EN
    localparam logic [31:0] CRC_INIT    = 32'hFFFF_FFFF;
    localparam logic [31:0] CRC_POLY_R  = 32'hEDB8_8320;
    // Register value left after running a good frame's own FCS through the CRC.
    localparam logic [31:0] CRC_RESIDUE = 32'hDEBB_20E3;

    logic [31:0] crc;
    logic        ovf, crc_err;

    function automatic logic [31:0] crc32_byte(input logic [31:0] c, input logic [7:0] b);
        logic [31:0] r;
        r = c ^ {24'd0, b};
        for (int i = 0; i < 8; i++) begin
            r = r[0] ? ((r >> 1) ^ CRC_POLY_R) : (r >> 1);
        end
        return r;
    endfunction

    always_ff @(posedge i_clk_50m or negedge i_rstn) begin
        if (!i_rstn) begin
            crc     <= CRC_INIT;
            ovf     <= 1'b0;
            crc_err <= 1'b0;
        end else begin
            crc_err <= frame_end_nxt && ((crc != CRC_RESIDUE) || (dcnt != 2'd0) || ovf);
            if (sfd_hit) begin
                crc <= CRC_INIT;
                ovf <= 1'b0;
            end else if (deliver) begin
                crc <= crc32_byte(crc, byte_nxt);
            end else if (byte_done) begin
                ovf <= 1'b1;
            end
        end
    end

    assign bus.o_crc_err = crc_err;
`else
    assign bus.o_crc_err = 1'b0;
`endif

endmodule
